// File: rtl/lif_spike_scheduler.sv
// Event scheduler feeding the LIF neuron: buffers input spike events, applies per-synapse weights,
// injects recurrent spikes and sequences timesteps. Optional LIF_SCHED_EVCNT_EN adds o_ev_cnt/o_drop.
module lif_spike_scheduler #(
  parameter int unsigned N_SYN      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned W_WIDTH    = 3,
  parameter int unsigned ST_WIDTH   = 4,
  parameter int unsigned TH_WIDTH   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_w_we,
  input  logic [$clog2(N_SYN)-1:0]  cfg_w_addr,
  input  logic [W_WIDTH-1:0]        cfg_w_data,
  input  logic [W_WIDTH-1:0]        cfg_rec_w,
  input  logic [TH_WIDTH-1:0]       cfg_thres,
  input  logic                      cfg_thres_we,
  input  logic                      step_start,
  input  logic                      ev_valid,
  input  logic [$clog2(N_SYN)-1:0]  ev_addr,
  input  logic                      ev_last,
  output logic                      ev_ready,
  input  logic                      i_spike,
  output logic [W_WIDTH-1:0]        o_wspike,
  output logic                      o_svalid,
  output logic [ST_WIDTH-1:0]       o_State,
  output logic                      o_recc,
  output logic [TH_WIDTH-1:0]       o_Thres,
  output logic                      o_Thres_valid,
  output logic                      step_done
`ifdef LIF_SCHED_EVCNT_EN
  ,
  output logic [7:0]                o_ev_cnt,
  output logic                      o_drop
`endif
);

  localparam int unsigned AW = $clog2(N_SYN);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_RECUR, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state;
  logic [W_WIDTH-1:0]   weight_q [N_SYN];
  logic [AW-1:0]        fifo_q   [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 last_seen;
  logic                 spk_q;
  logic [W_WIDTH-1:0]   rec_w;
  logic                 thres_pend;
  logic [TH_WIDTH-1:0]  thres_val;
  logic                 start_def;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 thres_req;
  logic                 start_req;
  logic [W_WIDTH-1:0]   head_w;

  // Head weight is read from the current registers, so a same-cycle write issues the old value
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign ev_ready  = (state == S_ISSUE) && !full;
  assign push      = ev_valid && ev_ready;
  assign pop       = (state == S_ISSUE) && !empty;
  assign thres_req = thres_pend || cfg_thres_we;
  assign start_req = step_start || start_def;
  assign head_w    = weight_q[fifo_q[rd_ptr]];

`ifdef LIF_SCHED_EVCNT_EN
  logic [7:0] ev_cnt_inc;
  assign ev_cnt_inc = (o_ev_cnt == 8'hFF) ? o_ev_cnt : o_ev_cnt + 8'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      for (int i = 0; i < int'(N_SYN); i++) weight_q[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      last_seen     <= 1'b0;
      spk_q         <= 1'b0;
      rec_w         <= '0;
      thres_pend    <= 1'b0;
      thres_val     <= '0;
      start_def     <= 1'b0;
      o_wspike      <= '0;
      o_svalid      <= 1'b0;
      o_State       <= '0;
      o_recc        <= 1'b0;
      o_Thres       <= '0;
      o_Thres_valid <= 1'b0;
      step_done     <= 1'b0;
`ifdef LIF_SCHED_EVCNT_EN
      o_ev_cnt      <= '0;
      o_drop        <= 1'b0;
`endif
    end else begin
      o_svalid      <= 1'b0;
      o_recc        <= 1'b0;
      o_Thres_valid <= 1'b0;
      step_done     <= 1'b0;

      if (cfg_w_we) weight_q[cfg_w_addr] <= cfg_w_data;
      if (cfg_thres_we) begin
        thres_pend <= 1'b1;
        thres_val  <= cfg_thres;
      end
      // Remember a neuron spike so the next step can start with a recurrent issue
      if (i_spike && (state == S_RECUR || state == S_ISSUE || state == S_WAIT)) spk_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (thres_req) begin
            o_Thres       <= cfg_thres_we ? cfg_thres : thres_val;
            o_Thres_valid <= 1'b1;
            thres_pend    <= 1'b0;
            if (step_start) start_def <= 1'b1;
          end else if (start_req) begin
            start_def <= 1'b0;
            o_State   <= o_State + ST_WIDTH'(1);
            rec_w     <= cfg_rec_w;
            spk_q     <= 1'b0;
            last_seen <= 1'b0;
`ifdef LIF_SCHED_EVCNT_EN
            o_ev_cnt  <= '0;
`endif
            state     <= spk_q ? S_RECUR : S_ISSUE;
          end
        end
        S_RECUR: begin
          o_svalid <= 1'b1;
          o_recc   <= 1'b1;
          o_wspike <= rec_w;
`ifdef LIF_SCHED_EVCNT_EN
          o_ev_cnt <= ev_cnt_inc;
`endif
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (push) begin
            fifo_q[wr_ptr] <= ev_addr;
            wr_ptr         <= wr_ptr + PW'(1);
            if (ev_last) last_seen <= 1'b1;
          end
          if (pop) begin
            o_svalid <= 1'b1;
            o_wspike <= head_w;
            rd_ptr   <= rd_ptr + PW'(1);
`ifdef LIF_SCHED_EVCNT_EN
            o_ev_cnt <= ev_cnt_inc;
`endif
          end
          count <= count + CW'(push) - CW'(pop);
`ifdef LIF_SCHED_EVCNT_EN
          if (ev_valid && !ev_ready) o_drop <= 1'b1;
`endif
          if (last_seen && empty && !push) state <= S_WAIT;
        end
        S_WAIT: begin
          step_done <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_spike_scheduler.sv
// Directed bench for lif_spike_scheduler: a queue-based model of expected weighted spikes,
// checked on every issue, plus literal expectations for key scenarios.
module tb_lif_spike_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_w_we;
  logic [3:0] cfg_w_addr;
  logic [2:0] cfg_w_data;
  logic [2:0] cfg_rec_w;
  logic [5:0] cfg_thres;
  logic       cfg_thres_we;
  logic       step_start;
  logic       ev_valid;
  logic [3:0] ev_addr;
  logic       ev_last;
  logic       ev_ready;
  logic       i_spike;
  logic [2:0] o_wspike;
  logic       o_svalid;
  logic [3:0] o_State;
  logic       o_recc;
  logic [5:0] o_Thres;
  logic       o_Thres_valid;
  logic       step_done;
`ifdef LIF_SCHED_EVCNT_EN
  logic [7:0] o_ev_cnt;
  logic       o_drop;
`endif

  lif_spike_scheduler dut (
    .clk(clk), .rst(rst), .cfg_w_we(cfg_w_we), .cfg_w_addr(cfg_w_addr), .cfg_w_data(cfg_w_data),
    .cfg_rec_w(cfg_rec_w), .cfg_thres(cfg_thres), .cfg_thres_we(cfg_thres_we),
    .step_start(step_start), .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_last(ev_last),
    .ev_ready(ev_ready), .i_spike(i_spike), .o_wspike(o_wspike), .o_svalid(o_svalid),
    .o_State(o_State), .o_recc(o_recc), .o_Thres(o_Thres), .o_Thres_valid(o_Thres_valid),
    .step_done(step_done)
`ifdef LIF_SCHED_EVCNT_EN
    , .o_ev_cnt(o_ev_cnt), .o_drop(o_drop)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: weight table, step counter, pending recurrent flag, expected issues {recc, weight}
  logic [2:0] m_w [16];
  int         m_state;
  bit         m_spk;
  int         m_cnt;
  logic [3:0] exp_q [$];
  logic [3:0] log_q [$];
  logic [3:0] ev_list [$];
  logic [3:0] cmp_e;
  int         base;
  int         stalls;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_svalid) begin
      log_q.push_back({o_recc, o_wspike});
      if (exp_q.size() == 0) check("spurious_issue", 1, 0);
      else begin
        cmp_e = exp_q.pop_front();
        check("issue_weight", int'(o_wspike), int'(cmp_e[2:0]));
        check("issue_recc", int'(o_recc), int'(cmp_e[3]));
      end
    end
  end

  task automatic wr_w(input logic [3:0] a, input logic [2:0] d);
    @(posedge clk); #1 cfg_w_we = 1'b1; cfg_w_addr = a; cfg_w_data = d;
    @(posedge clk); #1 cfg_w_we = 1'b0;
    m_w[a] = d;
  endtask

  task automatic model_accept(input logic [2:0] rw);
    m_cnt = 0;
    if (m_spk) begin
      exp_q.push_back({1'b1, rw});
      m_cnt = 1;
    end
    m_spk   = 1'b0;
    m_state = (m_state + 1) % 16;
  endtask

  task automatic run_step(input logic [2:0] rw, input bit spike, input bit thres, input logic [5:0] th);
    bit accepted;
    bit seen;
    stalls = 0;
    base   = log_q.size();
    if (thres) begin
      @(posedge clk); #1 cfg_thres = th; cfg_thres_we = 1'b1; step_start = 1'b1; cfg_rec_w = rw;
      @(posedge clk); #1 cfg_thres_we = 1'b0; step_start = 1'b0;
      @(negedge clk);
      check("thres_valid", int'(o_Thres_valid), 1);
      check("thres_value", int'(o_Thres), int'(th));
      check("state_deferred", int'(o_State), m_state);
      model_accept(rw);
      @(negedge clk);
      check("thres_pulse_end", int'(o_Thres_valid), 0);
      check("state_after_defer", int'(o_State), m_state);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1 step_start = 1'b1; cfg_rec_w = rw;
      @(posedge clk); #1 step_start = 1'b0;
      model_accept(rw);
    end
    foreach (ev_list[i]) begin
      ev_valid = 1'b1;
      ev_addr  = ev_list[i];
      ev_last  = (i == ev_list.size() - 1);
      i_spike  = spike && (i == 0);
      if (spike && i == 0) m_spk = 1'b1;
      accepted = 1'b0;
      for (int k = 0; k < 20 && !accepted; k++) begin
        @(negedge clk);
        if (ev_ready) begin
          accepted = 1'b1;
          exp_q.push_back({1'b0, m_w[ev_list[i]]});
          m_cnt++;
        end else stalls++;
        @(posedge clk); #1 i_spike = 1'b0;
      end
      if (!accepted) check("event_accept_timeout", 0, 1);
    end
    ev_valid = 1'b0;
    ev_last  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (step_done) seen = 1'b1;
    end
    if (!seen) check("step_done_timeout", 0, 1);
    check("state_at_done", int'(o_State), m_state);
    check("all_issued_at_done", exp_q.size(), 0);
`ifdef LIF_SCHED_EVCNT_EN
    check("ev_cnt_at_done", int'(o_ev_cnt), m_cnt);
`endif
    @(negedge clk);
    check("step_done_one_cycle", int'(step_done), 0);
  endtask

  initial begin
    rst = 1'b1; cfg_w_we = 1'b0; cfg_w_addr = '0; cfg_w_data = '0; cfg_rec_w = '0;
    cfg_thres = '0; cfg_thres_we = 1'b0; step_start = 1'b0; ev_valid = 1'b0;
    ev_addr = '0; ev_last = 1'b0; i_spike = 1'b0;
    foreach (m_w[i]) m_w[i] = '0;
    m_state = 0; m_spk = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_svalid", int'(o_svalid), 0);
    check("rst_state", int'(o_State), 0);
    check("rst_ev_ready", int'(ev_ready), 0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_thres_valid", int'(o_Thres_valid), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic weighted issue
    wr_w(4'd3, 3'd5);
    wr_w(4'd7, 3'd2);
    ev_list = '{4'd3, 4'd7};
    run_step(3'd4, 1'b0, 1'b0, 6'd0);
    check("lit_first_w5", int'(log_q[base]), 5);
    check("lit_second_w2", int'(log_q[base + 1]), 2);
    check("lit_state_1", int'(o_State), 1);

    // Spike in step 2 produces a recurrent issue at the start of step 3
    ev_list = '{4'd7, 4'd3};
    run_step(3'd4, 1'b1, 1'b0, 6'd0);
    ev_list = '{4'd3, 4'd7};
    run_step(3'd4, 1'b0, 1'b0, 6'd0);
    check("lit_recur_first", int'(log_q[base]), 4'hC);
    check("lit_after_recur", int'(log_q[base + 1]), 5);
    check("lit_after_recur2", int'(log_q[base + 2]), 2);

    // Six back-to-back events, pop keeps pace
    wr_w(4'd1, 3'd1);
    wr_w(4'd2, 3'd6);
    wr_w(4'd9, 3'd7);
    wr_w(4'd15, 3'd3);
    ev_list = '{4'd1, 4'd2, 4'd9, 4'd15, 4'd3, 4'd7};
    run_step(3'd1, 1'b0, 1'b0, 6'd0);
    check("no_backpressure", stalls, 0);
    check("lit_order_third", int'(log_q[base + 2]), 7);
    check("lit_order_sixth", int'(log_q[base + 5]), 2);

    // Threshold load colliding with step_start
    ev_list = '{4'd9};
    run_step(3'd2, 1'b0, 1'b1, 6'd40);

    // Walk the step counter through its wrap
    while (m_state != 0) begin
      ev_list = '{4'(m_state)};
      run_step(3'd3, (m_state == 8), 1'b0, 6'd0);
    end
    check("lit_state_wrap", int'(o_State), 0);

    // Reset in the middle of ISSUE with events in flight
    @(posedge clk); #1 step_start = 1'b1;
    @(posedge clk); #1 step_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev_valid = 1'b1; ev_addr = 4'(i + 1); i_spike = (i == 0);
      exp_q.push_back({1'b0, m_w[i + 1]});
      @(posedge clk); #1;
    end
    rst = 1'b1; ev_valid = 1'b0; i_spike = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    foreach (m_w[i]) m_w[i] = '0;
    m_state = 0; m_spk = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_issue_after_rst", int'(o_svalid), 0);
    end
    check("rst2_state", int'(o_State), 0);
    check("rst2_wspike", int'(o_wspike), 0);
    check("rst2_thres", int'(o_Thres), 0);
    check("rst2_ev_ready", int'(ev_ready), 0);
    ev_list = '{4'd3};
    run_step(3'd6, 1'b0, 1'b0, 6'd0);
    check("lit_weight_cleared", int'(log_q[base]), 0);
    check("lit_one_issue_post_rst", log_q.size() - base, 1);
    check("lit_state_post_rst", int'(o_State), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
